// File: rtl/fifo_wr_arb_ctrl.sv
// Async-FIFO write side: round-robin, burst-bounded arbitration of two producers onto one write port.
// Grants are same-cycle and combinational; all grants stall while wfull is set. Full/almost-full flags are registered.
module fifo_wr_arb_ctrl #(
  parameter int ADDRSIZE     = 4,
  parameter int DSIZE        = 8,
  parameter int AFULL_MARGIN = 2,
  parameter int MAX_BURST    = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                req0,
  input  logic [DSIZE-1:0]    wdata0,
  input  logic                req1,
  input  logic [DSIZE-1:0]    wdata1,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                gnt0,
  output logic                gnt1,
  output logic                winc,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [DSIZE-1:0]    wdata,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [ADDRSIZE:0] AFULL_TH = (ADDRSIZE+1)'((2 ** ADDRSIZE) - AFULL_MARGIN);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       burst_cnt_q, burst_cnt_d;
  logic                last_owner_q, last_owner_d;
  logic [ADDRSIZE:0]   wbin_q, wbin_d;
  logic [ADDRSIZE:0]   wptr_q, wptr_d;
  logic                wfull_q, wfull_d;
  logic                walmost_full_q, walmost_full_d;

  logic                g0, g1;
  logic [ADDRSIZE:0]   rbin;
  logic [ADDRSIZE:0]   used;

  // Arbitration; gated by reset so nothing is written while wrst_n is low.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (wrst_n && !wfull_q) begin
      case (state_q)
        IDLE: begin
          if (req0 && req1) begin
            g0 = last_owner_q;
            g1 = !last_owner_q;
          end else begin
            g0 = req0;
            g1 = req1;
          end
        end
        OWN0: begin
          if (req0 && (!req1 || burst_cnt_q < CNT_MAX)) g0 = 1'b1;
          else g1 = req1;
        end
        OWN1: begin
          if (req1 && (!req0 || burst_cnt_q < CNT_MAX)) g1 = 1'b1;
          else g0 = req0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    if (g0) begin
      state_d     = OWN0;
      burst_cnt_d = (state_q != OWN0) ? CW'(1) :
                    (burst_cnt_q < CNT_MAX) ? burst_cnt_q + CW'(1) : burst_cnt_q;
    end else if (g1) begin
      state_d     = OWN1;
      burst_cnt_d = (state_q != OWN1) ? CW'(1) :
                    (burst_cnt_q < CNT_MAX) ? burst_cnt_q + CW'(1) : burst_cnt_q;
    end else if (!wfull_q) begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end
    if (state_q == OWN0 && state_d != OWN0) last_owner_d = 1'b0;
    if (state_q == OWN1 && state_d != OWN1) last_owner_d = 1'b1;
  end

  // Each binary bit of the read pointer is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) rbin[i] = ^(wq2_rptr >> i);
  end

  always_comb begin
    wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, (g0 | g1)};
    wptr_d         = (wbin_d >> 1) ^ wbin_d;
    used           = wbin_d - rbin;
    wfull_d        = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    walmost_full_d = (used >= AFULL_TH);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q        <= IDLE;
      burst_cnt_q    <= '0;
      last_owner_q   <= 1'b1;
      wbin_q         <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      burst_cnt_q    <= burst_cnt_d;
      last_owner_q   <= last_owner_d;
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
    end
  end

  assign gnt0         = g0;
  assign gnt1         = g1;
  assign winc         = g0 | g1;
  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wdata        = g0 ? wdata0 : wdata1;
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;

endmodule
